// File: rtl/csr_mtrap.sv
// Machine-mode CSR file and trap controller.
// Holds the M-mode status, interrupt, trap and counter CSRs. It also decides,
// combinationally, whether the current instruction traps or returns via MRET.
// The resulting state commits at the next clock edge.
module csr_mtrap #(
    parameter int              XLEN       = 32,
    parameter int              CNT_WIDTH  = 64,
    parameter logic [XLEN-1:0] RESET_TVEC = '0,
    parameter int              HART_ID    = 0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_csr_en,
    input  logic [2:0]      i_funct3,
    input  logic [11:0]     i_addr,
    input  logic [XLEN-1:0] i_wd,
    output logic [XLEN-1:0] o_rd,
    output logic            o_csr_illegal,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_badaddr,
    input  logic            i_ex_inst_addr,
    input  logic            i_ex_illegal,
    input  logic            i_ebreak,
    input  logic            i_ecall,
    input  logic            i_ex_ld_addr,
    input  logic            i_ex_st_addr,
    input  logic            i_mret,
    input  logic            i_int_ok,
    input  logic            i_retire,
    input  logic            i_irq_sw,
    input  logic            i_irq_timer,
    input  logic            i_irq_ext,
    output logic            o_trap,
    output logic [XLEN-1:0] o_trap_pc,
    output logic [XLEN-1:0] o_cause,
    output logic            o_eret,
    output logic [XLEN-1:0] o_epc,
    output logic            o_irq_pending
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    // Only MSIE, MTIE and MEIE are implemented in mie.
    localparam logic [XLEN-1:0] MIE_MASK = XLEN'(12'h888);

    // Architectural state
    logic                 mst_mie;
    logic                 mst_mpie;
    logic [XLEN-1:0]      mie_q;
    logic [XLEN-1:0]      mtvec_q;
    logic [XLEN-1:0]      mscratch_q;
    logic [XLEN-1:0]      mepc_q;
    logic [XLEN-1:0]      mcause_q;
    logic [XLEN-1:0]      mtval_q;
    logic [2:0]           mip_q;      // {ext, timer, sw}
    logic [CNT_WIDTH-1:0] mcycle_q;
    logic [CNT_WIDTH-1:0] minstret_q;

    // Derived read views
    logic [XLEN-1:0]   mstatus_rd;
    logic [XLEN-1:0]   misa_val;
    logic [XLEN-1:0]   mip_full;
    logic [2*XLEN-1:0] cyc_ext;
    logic [2*XLEN-1:0] ins_ext;
    logic [2*XLEN-1:0] cyc_wr_ext;
    logic [2*XLEN-1:0] ins_wr_ext;

    // CSR access
    logic [XLEN-1:0] rd_val;
    logic            csr_exists;
    logic            csr_ro;
    logic [1:0]      op;
    logic            f3_valid;
    logic            wr_intent;
    logic [XLEN-1:0] wval;
    logic            csr_we;
    logic            wr_mstatus, wr_mie, wr_mtvec, wr_mscratch;
    logic            wr_mepc, wr_mcause, wr_mtval;
    logic            wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;

    // Trap arbitration
    logic            exc_any;
    logic [3:0]      exc_code;
    logic            exc_has_tval;
    logic [XLEN-1:0] pend;
    logic [3:0]      int_code;
    logic            int_take;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_tval;
    logic [XLEN-1:0] tvec_base;
    logic [XLEN-1:0] vec_off;

    // Assemble the read-only views of packed state
    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mst_mpie;
        mstatus_rd[3]     = mst_mie;

        misa_val              = '0;
        misa_val[XLEN-1:XLEN-2] = (XLEN == 64) ? 2'b10 : 2'b01;
        misa_val[8]           = 1'b1;

        mip_full     = '0;
        mip_full[11] = mip_q[2];
        mip_full[7]  = mip_q[1];
        mip_full[3]  = mip_q[0];

        cyc_ext                  = '0;
        cyc_ext[CNT_WIDTH-1:0]   = mcycle_q;
        ins_ext                  = '0;
        ins_ext[CNT_WIDTH-1:0]   = minstret_q;
    end

    // Address decode: read value, existence and read-only attribute
    always_comb begin
        rd_val     = '0;
        csr_exists = 1'b1;
        csr_ro     = 1'b0;
        case (i_addr)
            A_MSTATUS:  rd_val = mstatus_rd;
            A_MISA: begin
                rd_val = misa_val;
                csr_ro = 1'b1;
            end
            A_MIE:      rd_val = mie_q;
            A_MTVEC:    rd_val = mtvec_q;
            A_MSCRATCH: rd_val = mscratch_q;
            A_MEPC:     rd_val = mepc_q;
            A_MCAUSE:   rd_val = mcause_q;
            A_MTVAL:    rd_val = mtval_q;
            A_MIP: begin
                rd_val = mip_full;
                csr_ro = 1'b1;
            end
            A_MCYCLE:   rd_val = cyc_ext[XLEN-1:0];
            A_MINSTRET: rd_val = ins_ext[XLEN-1:0];
            A_MCYCLEH: begin
                if (XLEN == 32) rd_val = cyc_ext[2*XLEN-1:XLEN];
                else            csr_exists = 1'b0;
            end
            A_MINSTRETH: begin
                if (XLEN == 32) rd_val = ins_ext[2*XLEN-1:XLEN];
                else            csr_exists = 1'b0;
            end
            A_CYCLE: begin
                rd_val = cyc_ext[XLEN-1:0];
                csr_ro = 1'b1;
            end
            A_INSTRET: begin
                rd_val = ins_ext[XLEN-1:0];
                csr_ro = 1'b1;
            end
            A_CYCLEH: begin
                csr_ro = 1'b1;
                if (XLEN == 32) rd_val = cyc_ext[2*XLEN-1:XLEN];
                else            csr_exists = 1'b0;
            end
            A_INSTRETH: begin
                csr_ro = 1'b1;
                if (XLEN == 32) rd_val = ins_ext[2*XLEN-1:XLEN];
                else            csr_exists = 1'b0;
            end
            A_MHARTID: begin
                rd_val = XLEN'(HART_ID);
                csr_ro = 1'b1;
            end
            default: csr_exists = 1'b0;
        endcase
        if (!csr_exists) begin
            rd_val = '0;
            csr_ro = 1'b0;
        end
    end

    // Compute the write value and whether this access really writes.
    // RS/RC with a zero operand are pure reads, so they are legal on RO CSRs.
    always_comb begin
        op        = i_funct3[1:0];
        f3_valid  = (i_funct3 != 3'b000) && (i_funct3 != 3'b100);
        wr_intent = f3_valid && ((op == 2'b01) || (i_wd != '0));
        case (op)
            2'b01:   wval = i_wd;
            2'b10:   wval = rd_val | i_wd;
            2'b11:   wval = rd_val & ~i_wd;
            default: wval = rd_val;
        endcase
    end

    assign o_rd          = rd_val;
    assign o_csr_illegal = i_csr_en && (!csr_exists || (csr_ro && wr_intent));
    assign csr_we        = i_csr_en && csr_exists && !csr_ro && wr_intent && !o_trap;

    assign wr_mstatus   = csr_we && (i_addr == A_MSTATUS);
    assign wr_mie       = csr_we && (i_addr == A_MIE);
    assign wr_mtvec     = csr_we && (i_addr == A_MTVEC);
    assign wr_mscratch  = csr_we && (i_addr == A_MSCRATCH);
    assign wr_mepc      = csr_we && (i_addr == A_MEPC);
    assign wr_mcause    = csr_we && (i_addr == A_MCAUSE);
    assign wr_mtval     = csr_we && (i_addr == A_MTVAL);
    assign wr_mcycle    = csr_we && (i_addr == A_MCYCLE);
    assign wr_minstret  = csr_we && (i_addr == A_MINSTRET);
    assign wr_mcycleh   = csr_we && (i_addr == A_MCYCLEH);
    assign wr_minstreth = csr_we && (i_addr == A_MINSTRETH);

    // Synchronous exception arbitration, highest priority first
    always_comb begin
        exc_any      = 1'b1;
        exc_code     = 4'd0;
        exc_has_tval = 1'b0;
        if (i_ex_inst_addr) begin
            exc_code     = 4'd0;
            exc_has_tval = 1'b1;
        end else if (i_ex_illegal) begin
            exc_code = 4'd2;
        end else if (i_ebreak) begin
            exc_code = 4'd3;
        end else if (i_ecall) begin
            exc_code = 4'd11;
        end else if (i_ex_ld_addr) begin
            exc_code     = 4'd4;
            exc_has_tval = 1'b1;
        end else if (i_ex_st_addr) begin
            exc_code     = 4'd6;
            exc_has_tval = 1'b1;
        end else begin
            exc_any = 1'b0;
        end
    end

    // Interrupt arbitration: external, then software, then timer
    always_comb begin
        pend = mip_full & mie_q;
        if (pend[11])     int_code = 4'd11;
        else if (pend[3]) int_code = 4'd3;
        else              int_code = 4'd7;
    end

    assign o_irq_pending = |pend;
    assign int_take      = mst_mie && o_irq_pending && i_int_ok && !exc_any;
    assign o_trap        = exc_any || int_take;

    // Trap cause, fault value and target PC
    always_comb begin
        trap_cause         = '0;
        trap_cause[3:0]    = exc_any ? exc_code : int_code;
        trap_cause[XLEN-1] = !exc_any;
        trap_tval          = (exc_any && exc_has_tval) ? i_badaddr : '0;
        tvec_base          = {mtvec_q[XLEN-1:2], 2'b00};
        vec_off            = '0;
        vec_off[5:2]       = int_code;
        if (!o_trap)
            o_trap_pc = '0;
        else if (int_take && (mtvec_q[1:0] == 2'b01))
            o_trap_pc = tvec_base + vec_off;
        else
            o_trap_pc = tvec_base;
    end

    assign o_cause = o_trap ? trap_cause : '0;
    assign o_eret  = i_mret && !o_trap;
    assign o_epc   = o_eret ? mepc_q : '0;

    // mstatus stacking: trap entry beats MRET, which beats a CSR write
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            mst_mie  <= 1'b0;
            mst_mpie <= 1'b0;
        end else if (o_trap) begin
            mst_mpie <= mst_mie;
            mst_mie  <= 1'b0;
        end else if (o_eret) begin
            mst_mie  <= mst_mpie;
            mst_mpie <= 1'b1;
        end else if (wr_mstatus) begin
            mst_mie  <= wval[3];
            mst_mpie <= wval[7];
        end
    end

    // Software-writable configuration CSRs
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            mie_q      <= '0;
            mtvec_q    <= {RESET_TVEC[XLEN-1:2], 2'b00};
            mscratch_q <= '0;
        end else begin
            if (wr_mie)      mie_q      <= wval & MIE_MASK;
            if (wr_mtvec)    mtvec_q    <= {wval[XLEN-1:2], (wval[1] ? mtvec_q[1:0] : wval[1:0])};
            if (wr_mscratch) mscratch_q <= wval;
        end
    end

    // Trap entry captures return PC, cause and fault value
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            mepc_q   <= '0;
            mcause_q <= '0;
            mtval_q  <= '0;
        end else if (o_trap) begin
            mepc_q   <= {i_pc[XLEN-1:2], 2'b00};
            mcause_q <= trap_cause;
            mtval_q  <= trap_tval;
        end else begin
            if (wr_mepc)   mepc_q   <= {wval[XLEN-1:2], 2'b00};
            if (wr_mcause) mcause_q <= wval;
            if (wr_mtval)  mtval_q  <= wval;
        end
    end

    // Interrupt lines are registered, giving mip one cycle of latency
    always_ff @(posedge i_clk) begin
        if (!i_rst) mip_q <= '0;
        else        mip_q <= {i_irq_ext, i_irq_timer, i_irq_sw};
    end

    // Half-word counter writes merge into the full counter value
    always_comb begin
        cyc_wr_ext = cyc_ext;
        ins_wr_ext = ins_ext;
        if (wr_mcycle)    cyc_wr_ext[XLEN-1:0]      = wval;
        if (wr_mcycleh)   cyc_wr_ext[2*XLEN-1:XLEN] = wval;
        if (wr_minstret)  ins_wr_ext[XLEN-1:0]      = wval;
        if (wr_minstreth) ins_wr_ext[2*XLEN-1:XLEN] = wval;
    end

    // Cycle counter: a write replaces the increment for that cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst)
            mcycle_q <= '0;
        else if (wr_mcycle || wr_mcycleh)
            mcycle_q <= cyc_wr_ext[CNT_WIDTH-1:0];
        else
            mcycle_q <= mcycle_q + CNT_WIDTH'(1);
    end

    // Retired-instruction counter: trapping instructions do not retire
    always_ff @(posedge i_clk) begin
        if (!i_rst)
            minstret_q <= '0;
        else if (wr_minstret || wr_minstreth)
            minstret_q <= ins_wr_ext[CNT_WIDTH-1:0];
        else if (i_retire && !o_trap)
            minstret_q <= minstret_q + CNT_WIDTH'(1);
    end

endmodule

// File: tb/tb_csr_mtrap.sv
// Bench for csr_mtrap (XLEN=32): directed scenarios followed by random traffic,
// all outputs compared each cycle against a behavioural model of the CSR file.
module tb_csr_mtrap;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_en;
    logic [2:0]  funct3;
    logic [11:0] addr;
    logic [31:0] wd, pc, badaddr;
    logic        ex_ia, ex_ill, ebreak, ecall, ex_ld, ex_st;
    logic        mret, int_ok, retire, irq_sw, irq_timer, irq_ext;
    logic [31:0] rd, trap_pc, cause, epc;
    logic        csr_illegal, trap, eret, irq_pending;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_mie, m_mpie;
    logic [31:0] m_ien = '0, m_tvec = '0, m_scratch = '0, m_epc = '0;
    logic [31:0] m_cause = '0, m_tval = '0, m_ip = '0;
    logic [63:0] m_cyc = '0, m_ins = '0;

    // Model predictions for the current inputs
    bit          e_trap, e_exc, e_int, e_eret, e_ill, e_pend, e_wr;
    logic [31:0] e_rd, e_cause, e_tpc, e_epc;
    int          e_code, e_icode;

    logic [11:0] alist [19] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                                12'hB82, 12'hC00, 12'hC02, 12'hC80, 12'hC82, 12'hF14, 12'h7C0};
    logic [2:0]  f3list [6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

    always #5 clk = ~clk;

    csr_mtrap dut (
        .i_clk(clk), .i_rst(rst),
        .i_csr_en(csr_en), .i_funct3(funct3), .i_addr(addr), .i_wd(wd),
        .o_rd(rd), .o_csr_illegal(csr_illegal),
        .i_pc(pc), .i_badaddr(badaddr),
        .i_ex_inst_addr(ex_ia), .i_ex_illegal(ex_ill), .i_ebreak(ebreak),
        .i_ecall(ecall), .i_ex_ld_addr(ex_ld), .i_ex_st_addr(ex_st),
        .i_mret(mret), .i_int_ok(int_ok), .i_retire(retire),
        .i_irq_sw(irq_sw), .i_irq_timer(irq_timer), .i_irq_ext(irq_ext),
        .o_trap(trap), .o_trap_pc(trap_pc), .o_cause(cause),
        .o_eret(eret), .o_epc(epc), .o_irq_pending(irq_pending)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a, output bit ex, output bit ro);
        ex = 1'b1;
        ro = 1'b0;
        case (a)
            12'h300: return 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
            12'h301: begin ro = 1'b1; return 32'h4000_0100; end
            12'h304: return m_ien;
            12'h305: return m_tvec;
            12'h340: return m_scratch;
            12'h341: return m_epc;
            12'h342: return m_cause;
            12'h343: return m_tval;
            12'h344: begin ro = 1'b1; return m_ip; end
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ins[31:0];
            12'hB82: return m_ins[63:32];
            12'hC00: begin ro = 1'b1; return m_cyc[31:0]; end
            12'hC80: begin ro = 1'b1; return m_cyc[63:32]; end
            12'hC02: begin ro = 1'b1; return m_ins[31:0]; end
            12'hC82: begin ro = 1'b1; return m_ins[63:32]; end
            12'hF14: begin ro = 1'b1; return 32'h0; end
            default: begin ex = 1'b0; return 32'h0; end
        endcase
    endfunction

    task automatic predict();
        bit          req [6];
        int          codes [6];
        int          prio [3];
        logic [31:0] pend;
        bit          ex, ro, intent;
        int          opv;
        req   = '{ex_ia, ex_ill, ebreak, ecall, ex_ld, ex_st};
        codes = '{0, 2, 3, 11, 4, 6};
        prio  = '{11, 3, 7};
        e_exc = 1'b0;
        e_code = 0;
        for (int i = 0; i < 6; i++)
            if (req[i] && !e_exc) begin
                e_exc  = 1'b1;
                e_code = codes[i];
            end
        pend    = m_ip & m_ien;
        e_pend  = (pend != 0);
        e_icode = 7;
        for (int i = 2; i >= 0; i--)
            if (pend[prio[i]]) e_icode = prio[i];
        e_int   = !e_exc && m_mie && e_pend && int_ok;
        e_trap  = e_exc || e_int;
        e_cause = e_exc ? 32'(e_code) : (e_int ? (32'h8000_0000 | 32'(e_icode)) : 32'h0);
        if (!e_trap)                          e_tpc = 32'h0;
        else if (e_int && m_tvec[1:0] == 2'b01) e_tpc = (m_tvec & ~32'h3) + 32'(4 * e_icode);
        else                                  e_tpc = m_tvec & ~32'h3;
        e_eret = mret && !e_trap;
        e_epc  = e_eret ? m_epc : 32'h0;
        e_rd   = m_read(addr, ex, ro);
        opv    = int'(funct3[1:0]);
        intent = (opv == 1) || (opv >= 2 && wd != 0);
        e_ill  = csr_en && (!ex || (ro && intent));
        e_wr   = csr_en && ex && !ro && intent && !e_trap;
    endtask

    task automatic commit();
        logic [31:0] wv;
        logic [63:0] ncyc, nins;
        bit          old_mpie;
        predict();
        if (!rst) begin
            m_mie = 0; m_mpie = 0; m_ien = 0; m_tvec = 0; m_scratch = 0;
            m_epc = 0; m_cause = 0; m_tval = 0; m_ip = 0; m_cyc = 0; m_ins = 0;
            return;
        end
        ncyc     = m_cyc + 64'd1;
        nins     = m_ins + ((retire && !e_trap) ? 64'd1 : 64'd0);
        old_mpie = m_mpie;
        if (e_trap) begin
            m_epc   = pc & ~32'h3;
            m_cause = e_cause;
            m_tval  = (e_exc && (e_code == 0 || e_code == 4 || e_code == 6)) ? badaddr : 32'h0;
            m_mpie  = m_mie;
            m_mie   = 1'b0;
        end else begin
            if (e_wr) begin
                case (funct3[1:0])
                    2'b01:   wv = wd;
                    2'b10:   wv = e_rd | wd;
                    default: wv = e_rd & ~wd;
                endcase
                case (addr)
                    12'h300: begin m_mie = wv[3]; m_mpie = wv[7]; end
                    12'h304: m_ien = wv & 32'h888;
                    12'h305: m_tvec = {wv[31:2], (wv[1] ? m_tvec[1:0] : wv[1:0])};
                    12'h340: m_scratch = wv;
                    12'h341: m_epc = wv & ~32'h3;
                    12'h342: m_cause = wv;
                    12'h343: m_tval = wv;
                    12'hB00: begin ncyc = m_cyc; ncyc[31:0]  = wv; end
                    12'hB80: begin ncyc = m_cyc; ncyc[63:32] = wv; end
                    12'hB02: begin nins = m_ins; nins[31:0]  = wv; end
                    12'hB82: begin nins = m_ins; nins[63:32] = wv; end
                    default: ;
                endcase
            end
            if (mret) begin
                m_mie  = old_mpie;
                m_mpie = 1'b1;
            end
        end
        m_cyc = ncyc;
        m_ins = nins;
        m_ip  = (irq_ext ? 32'h800 : 32'h0) | (irq_timer ? 32'h80 : 32'h0) | (irq_sw ? 32'h8 : 32'h0);
    endtask

    task automatic settle();
        @(negedge clk);
        predict();
        chk("rd", rd, e_rd);
        chk("csr_illegal", csr_illegal, e_ill);
        chk("trap", trap, e_trap);
        chk("trap_pc", trap_pc, e_tpc);
        chk("cause", cause, e_cause);
        chk("eret", eret, e_eret);
        chk("epc", epc, e_epc);
        chk("irq_pending", irq_pending, e_pend);
    endtask

    task automatic adv();
        commit();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        settle();
        adv();
    endtask

    task automatic idle();
        csr_en = 0; funct3 = 0; addr = 0; wd = 0; pc = 0; badaddr = 0;
        ex_ia = 0; ex_ill = 0; ebreak = 0; ecall = 0; ex_ld = 0; ex_st = 0;
        mret = 0; int_ok = 0; retire = 0; irq_sw = 0; irq_timer = 0; irq_ext = 0;
    endtask

    task automatic csr(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] w);
        idle();
        csr_en = 1; funct3 = f3; addr = a; wd = w;
    endtask

    task automatic rd_chk(input logic [11:0] a, input logic [31:0] exp, input string tag);
        csr(3'd2, a, 32'h0);
        settle();
        chk(tag, rd, exp);
        adv();
    endtask

    initial begin
        idle();
        rst = 0;
        adv();
        adv();
        rst = 1;

        // Out of reset with all inputs low, every output is zero
        settle();
        chk("rst_rd", rd, 0);
        chk("rst_trap", trap, 0);
        chk("rst_trap_pc", trap_pc, 0);
        chk("rst_cause", cause, 0);
        chk("rst_irq_pending", irq_pending, 0);
        adv();
        for (int i = 0; i < 9; i++) tick();
        rd_chk(12'hB00, 32'd10, "mcycle_after_10");
        rd_chk(12'h305, 32'h0, "mtvec_reset");

        // mstatus RW then RC
        csr(3'd1, 12'h300, 32'h88);
        settle(); chk("mstatus_rw_old", rd, 32'h1800); adv();
        csr(3'd3, 12'h300, 32'h8);
        settle(); chk("mstatus_rc_old", rd, 32'h1888); adv();
        rd_chk(12'h300, 32'h1880, "mstatus_after_rc");

        // Load address misaligned trap and MRET
        csr(3'd2, 12'h300, 32'h8); tick();
        idle(); ex_ld = 1; pc = 32'h100; badaddr = 32'h103;
        settle();
        chk("ld_trap", trap, 1);
        chk("ld_cause", cause, 4);
        chk("ld_trap_pc", trap_pc, 0);
        adv();
        rd_chk(12'h341, 32'h100, "ld_mepc");
        rd_chk(12'h342, 32'h4, "ld_mcause");
        rd_chk(12'h343, 32'h103, "ld_mtval");
        rd_chk(12'h300, 32'h1880, "ld_mstatus");
        idle(); mret = 1;
        settle(); chk("mret_eret", eret, 1); chk("mret_epc", epc, 32'h100); adv();
        rd_chk(12'h300, 32'h1888, "mret_mstatus");

        // Vectored interrupt, ext beats timer, one cycle mip latency
        csr(3'd1, 12'h305, 32'h201); tick();
        csr(3'd1, 12'h304, 32'h880); tick();
        idle(); irq_timer = 1; irq_ext = 1; int_ok = 1;
        settle(); chk("irq_latency", trap, 0); adv();
        settle();
        chk("irq_trap", trap, 1);
        chk("irq_cause", cause, 32'h8000_000B);
        chk("irq_trap_pc", trap_pc, 32'h22C);
        adv();
        rd_chk(12'h342, 32'h8000_000B, "irq_mcause");

        // mtvec MODE 2/3 keeps the old MODE
        csr(3'd1, 12'h305, 32'h303); tick();
        rd_chk(12'h305, 32'h301, "mtvec_mode_keep");

        // mcycle carry into the high half
        csr(3'd1, 12'hB00, 32'hFFFF_FFFF); tick();
        rd_chk(12'hB00, 32'hFFFF_FFFF, "mcycle_preset");
        rd_chk(12'hB00, 32'h0, "mcycle_wrap_lo");
        rd_chk(12'hB80, 32'h1, "mcycleh_carry");

        // Illegal accesses and legal reads of read-only CSRs
        csr(3'd1, 12'hC00, 32'h5);
        settle(); chk("ro_write_illegal", csr_illegal, 1); adv();
        csr(3'd2, 12'h7C0, 32'h5);
        settle(); chk("unimpl_illegal", csr_illegal, 1); chk("unimpl_rd", rd, 0); adv();
        csr(3'd2, 12'hC00, 32'h0);
        settle(); chk("cycle_read_legal", csr_illegal, 0); chk("cycle_shadow", rd, m_cyc[31:0]); adv();
        csr(3'd3, 12'h301, 32'h0);
        settle(); chk("misa_rc0_legal", csr_illegal, 0); chk("misa", rd, 32'h4000_0100); adv();

        // Reset dominates a trap in the same cycle
        csr(3'd2, 12'h300, 32'h8); tick();
        idle(); ex_ill = 1; pc = 32'h444; rst = 0;
        adv();
        rst = 1;
        rd_chk(12'h341, 32'h0, "rst_trap_mepc");
        rd_chk(12'h300, 32'h1800, "rst_trap_mstatus");

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            int idx;
            idle();
            rst = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 1) == 1) begin
                csr_en = 1;
                funct3 = f3list[$urandom_range(0, 5)];
                idx = $urandom_range(0, 19);
                addr = (idx == 19) ? 12'($urandom_range(0, 4095)) : alist[idx];
                wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            end
            ex_ia  = ($urandom_range(0, 29) == 0);
            ex_ill = ($urandom_range(0, 29) == 0);
            ebreak = ($urandom_range(0, 29) == 0);
            ecall  = ($urandom_range(0, 29) == 0);
            ex_ld  = ($urandom_range(0, 29) == 0);
            ex_st  = ($urandom_range(0, 29) == 0);
            mret   = ($urandom_range(0, 7) == 0);
            int_ok = ($urandom_range(0, 3) != 0);
            retire = ($urandom_range(0, 1) == 1);
            irq_sw    = ($urandom_range(0, 2) == 0);
            irq_timer = ($urandom_range(0, 2) == 0);
            irq_ext   = ($urandom_range(0, 2) == 0);
            pc      = $urandom;
            badaddr = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
